// File: rtl/hpi_bus_transactor.sv
// hpi_bus_transactor: Avalon-MM slave that turns single 16-bit read/write
// requests into timed CY7C67200 HPI bus cycles. Every HPI pin and every
// Avalon output comes straight from a flop, so the bus sees no glitches.
module hpi_bus_transactor #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    // Counter reload values: a phase of N clocks loads N-1 and ends when it hits 0.
    localparam logic [3:0] SETUP_LOAD    = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD   = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD     = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       is_write_r;

    // Bus-cycle sequencer; outputs are assigned alongside the transition so
    // they always reflect the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 4'd0;
            is_write_r      <= 1'b0;
            readdata        <= 16'h0000;
            waitrequest     <= 1'b1;
            otg_hpi_address <= 2'd0;
            otg_hpi_cs_n    <= 1'b1;
            otg_hpi_r_n     <= 1'b1;
            otg_hpi_w_n     <= 1'b1;
            otg_data_out    <= 16'h0000;
            otg_data_oe     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // read & write together resolves to a write
                    if (chipselect && (read || write)) begin
                        state_r         <= ST_SETUP;
                        cnt_r           <= SETUP_LOAD;
                        is_write_r      <= write;
                        otg_hpi_address <= address;
                        otg_hpi_cs_n    <= 1'b0;
                        otg_data_out    <= writedata;
                        otg_data_oe     <= write;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_STROBE;
                        cnt_r       <= STROBE_LOAD;
                        otg_hpi_r_n <= is_write_r;
                        otg_hpi_w_n <= ~is_write_r;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= HOLD_LOAD;
                        otg_hpi_r_n <= 1'b1;
                        otg_hpi_w_n <= 1'b1;
                        // capture on the edge that ends the read strobe
                        if (!is_write_r) begin
                            readdata <= otg_data_in;
                        end else begin
                            readdata <= readdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 4'd0) begin
                        state_r      <= ST_ACK;
                        otg_hpi_cs_n <= 1'b1;
                        otg_data_oe  <= 1'b0;
                        waitrequest  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_r     <= ST_RECOVER;
                    cnt_r       <= RECOVERY_LOAD;
                    waitrequest <= 1'b1;
                end
                ST_RECOVER: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 4'd0;
                    waitrequest  <= 1'b1;
                    otg_hpi_cs_n <= 1'b1;
                    otg_hpi_r_n  <= 1'b1;
                    otg_hpi_w_n  <= 1'b1;
                    otg_data_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_bus_transactor.sv
// Self-checking bench for hpi_bus_transactor: table-driven single
// transactions plus hand-written reset, back-to-back and abort sequences.
module tb_hpi_bus_transactor;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_hpi_address;
    logic        otg_hpi_cs_n;
    logic        otg_hpi_r_n;
    logic        otg_hpi_w_n;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic        exp_bus_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [5];
    vec_t post_vec;

    hpi_bus_transactor dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .chipselect      (chipselect),
        .read            (read),
        .write           (write),
        .writedata       (writedata),
        .readdata        (readdata),
        .waitrequest     (waitrequest),
        .otg_hpi_address (otg_hpi_address),
        .otg_hpi_cs_n    (otg_hpi_cs_n),
        .otg_hpi_r_n     (otg_hpi_r_n),
        .otg_hpi_w_n     (otg_hpi_w_n),
        .otg_data_out    (otg_data_out),
        .otg_data_oe     (otg_data_oe),
        .otg_data_in     (otg_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete transaction from IDLE; leaves the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int lat = -1;
        int acks = 0;
        int cs_low = 0;
        int r_low = 0;
        int w_low = 0;
        int oe_cyc = 0;
        int addr_bad = 0;
        int dout_bad = 0;
        int proto_bad = 0;
        logic [15:0] rd_ack = 16'h0000;
        @(negedge clk);
        chipselect = 1'b1;
        read       = v.rd;
        write      = v.wr;
        address    = v.addr;
        writedata  = v.wdata;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                address   = ~v.addr;
                writedata = ~v.wdata;
            end
            @(negedge clk);
            if (!otg_hpi_cs_n) begin
                cs_low++;
                if (otg_hpi_address !== v.addr) addr_bad++;
            end
            if (!otg_hpi_r_n) r_low++;
            if (!otg_hpi_w_n) begin
                w_low++;
                if (otg_data_out !== v.wdata) dout_bad++;
            end
            if (otg_data_oe) oe_cyc++;
            if ((!otg_hpi_r_n && !otg_hpi_w_n) ||
                ((!otg_hpi_r_n || !otg_hpi_w_n) && otg_hpi_cs_n) ||
                (otg_data_oe && !v.exp_bus_wr)) proto_bad++;
            otg_data_in = (!otg_hpi_r_n) ? v.din : 16'h0000;
            if (!waitrequest) begin
                acks++;
                if (lat < 0) lat = k + 1;
                rd_ack     = readdata;
                chipselect = 1'b0;
                read       = 1'b0;
                write      = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, 7);
        check({tag, "_ack_count"}, acks, 1);
        check({tag, "_cs_low"}, cs_low, 6);
        check({tag, "_r_low"}, r_low, v.exp_bus_wr ? 0 : 4);
        check({tag, "_w_low"}, w_low, v.exp_bus_wr ? 4 : 0);
        check({tag, "_oe_cycles"}, oe_cyc, v.exp_bus_wr ? 6 : 0);
        check({tag, "_addr_bad"}, addr_bad, 0);
        check({tag, "_dout_bad"}, dout_bad, 0);
        check({tag, "_protocol"}, proto_bad, 0);
        check({tag, "_readdata_ack"}, rd_ack, v.exp_rd);
        check({tag, "_readdata_held"}, readdata, v.exp_rd);
        check({tag, "_idle_cs_n"}, otg_hpi_cs_n, 1'b1);
    endtask

    int   starts [2];
    int   nstart;
    int   run_len;
    int   gap;
    int   acks4;
    logic prev_cs;
    int   acks5;
    int   cs5;
    int   acks1;
    logic [15:0] rd1;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 1'b1, 16'hA5A5};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 16'h00FF, 16'h1111, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h5A3C, 1'b0, 16'h5A3C};
        vecs[4] = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h5A3C};
        post_vec = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0BAD, 1'b0, 16'h0BAD};

        // Reset for two clocks with a read pending
        reset       = 1'b1;
        chipselect  = 1'b1;
        read        = 1'b1;
        write       = 1'b0;
        address     = 2'd3;
        writedata   = 16'h0000;
        otg_data_in = 16'hA5A5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", otg_hpi_cs_n, 1'b1);
        check("rst_r_n", otg_hpi_r_n, 1'b1);
        check("rst_w_n", otg_hpi_w_n, 1'b1);
        check("rst_oe", otg_data_oe, 1'b0);
        check("rst_readdata", readdata, 16'h0000);
        check("rst_waitrequest", waitrequest, 1'b1);
        check("rst_address", otg_hpi_address, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_accept_cs_n", otg_hpi_cs_n, 1'b0);
        check("rst_accept_addr", otg_hpi_address, 2'd3);
        acks1 = 0;
        rd1   = 16'h0000;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (!waitrequest) begin
                acks1++;
                rd1        = readdata;
                chipselect = 1'b0;
                read       = 1'b0;
            end
        end
        check("rst_read_acks", acks1, 1);
        check("rst_read_data", rd1, 16'hA5A5);

        // Table of single transactions
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back write then read with the request held continuously
        nstart  = 0;
        run_len = 0;
        gap     = 0;
        acks4   = 0;
        prev_cs = 1'b1;
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = 2'd2;
        writedata  = 16'h0A0A;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (otg_hpi_cs_n) begin
                run_len++;
            end else begin
                if (prev_cs && nstart < 2) begin
                    starts[nstart] = k;
                    nstart++;
                    if (nstart == 2) gap = run_len;
                end
                run_len = 0;
            end
            prev_cs = otg_hpi_cs_n;
            otg_data_in = (!otg_hpi_r_n) ? 16'h7E57 : 16'h0000;
            if (!waitrequest) begin
                acks4++;
                if (acks4 == 1) begin
                    write   = 1'b0;
                    read    = 1'b1;
                    address = 2'd0;
                end else begin
                    chipselect = 1'b0;
                    read       = 1'b0;
                end
            end
        end
        check("b2b_starts", nstart, 2);
        check("b2b_period", starts[1] - starts[0], 10);
        check("b2b_gap_ge3", (gap >= 3) ? 1 : 0, 1);
        check("b2b_acks", acks4, 2);
        check("b2b_readdata", readdata, 16'h7E57);

        // Reset during the strobe of a write
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = 2'd2;
        writedata  = 16'hCAFE;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_in_strobe", otg_hpi_w_n, 1'b0);
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_w_n", otg_hpi_w_n, 1'b1);
        check("abort_cs_n", otg_hpi_cs_n, 1'b1);
        check("abort_oe", otg_data_oe, 1'b0);
        check("abort_waitrequest", waitrequest, 1'b1);
        check("abort_data_out", otg_data_out, 16'h0000);
        reset = 1'b0;
        acks5 = 0;
        cs5   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!waitrequest) acks5++;
            if (!otg_hpi_cs_n) cs5++;
        end
        check("abort_no_ack", acks5, 0);
        check("abort_no_cs", cs5, 0);
        run_vec(post_vec, "post_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
